// File: rtl/tick_irq_ctrl.sv
// tick_irq_ctrl: MMU09 interrupt controller at $FE9x with synchronised UART/CH375/RTC
// lines, a programmable periodic tick, masking, and registered IRQ/FIRQ outputs.
module tick_irq_ctrl #(
  parameter int TICK_DIV = 20000
) (
  input  logic       i_eclk,
  input  logic       i_reset,
  input  logic       i_cs,
  input  logic       i_rw,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_data_oe,
  input  logic       i_uartirq,
  input  logic       i_chirq,
  input  logic       i_rtcirq,
  output logic       irq_n,
  output logic       firq_n
);
  localparam logic [15:0] DIV_TOP = 16'(TICK_DIV - 1);
  logic [2:0] sync1_q, sync2_q;
  logic pend_q, pend_d, ovr_q, ovr_d, ten_q, ten_d;
  logic irq_n_q, irq_n_d, firq_n_q, firq_n_d;
  logic [3:0] mask_q, mask_d;
  logic [15:0] div_q, div_d;
  logic [7:0] tcount_q, tcount_d;
  logic [4:0] status;
  logic wr, wr_stat, wr_mask, wr_tctrl, clr_pend, tick;
  always_comb begin
    status = {ovr_q, ~sync2_q, pend_q};
    wr = i_cs & ~i_rw;
    wr_stat = wr & (i_addr == 2'd0);
    wr_mask = wr & (i_addr == 2'd1);
    wr_tctrl = wr & (i_addr == 2'd2);
    clr_pend = wr_stat & i_data[0];
    // a TCTRL write restarts the divider and suppresses a tick due on the same edge
    tick = ten_q & (div_q == DIV_TOP) & ~wr_tctrl;
    div_d = wr_tctrl ? 16'd0 : ~ten_q ? div_q : (div_q == DIV_TOP) ? 16'd0 : div_q + 16'd1;
    ten_d = wr_tctrl ? i_data[0] : ten_q;
    mask_d = wr_mask ? i_data[3:0] : mask_q;
    pend_d = tick | (pend_q & ~clr_pend);
    ovr_d = (tick & pend_q & ~clr_pend) | (ovr_q & ~(wr_stat & i_data[4]));
    tcount_d = tcount_q + {7'd0, tick};
    irq_n_d = ~|(status[3:0] & mask_q & 4'b1011);
    firq_n_d = ~(status[2] & mask_q[2]);
    o_data_oe = i_cs & i_rw & i_eclk;
    o_data = ~o_data_oe ? 8'h00 :
             (i_addr == 2'd0) ? {3'b000, status} :
             (i_addr == 2'd1) ? {4'h0, mask_q} :
             (i_addr == 2'd2) ? {7'd0, ten_q} : tcount_q;
  end
  always_ff @(posedge i_eclk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      pend_q <= 1'b0;
      ovr_q <= 1'b0;
      ten_q <= 1'b0;
      mask_q <= 4'h0;
      div_q <= 16'd0;
      tcount_q <= 8'h00;
      irq_n_q <= 1'b1;
      firq_n_q <= 1'b1;
    end else begin
      sync1_q <= {i_rtcirq, i_chirq, i_uartirq};
      sync2_q <= sync1_q;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
      ten_q <= ten_d;
      mask_q <= mask_d;
      div_q <= div_d;
      tcount_q <= tcount_d;
      irq_n_q <= irq_n_d;
      firq_n_q <= firq_n_d;
    end
  end
  assign irq_n = irq_n_q;
  assign firq_n = firq_n_q;
endmodule
